// File: rtl/led_read_arbiter_if.sv
// led_read_arbiter_if
//   Bundles every non-clock signal of led_read_arbiter.
//
//   Handshake rules:
//   - req_request[i] is a level request.
//   - The arbiter samples req_address[i] only in the cycle it grants channel i.
//     Changing the request or the address after that does not cancel the read.
//   - mem_request stays high, with mem_address stable, until the memory pulses
//     mem_done or the arbiter aborts the read.
//   - mem_read_data is taken in the mem_done cycle.
//   - rsp_strobe is a one-hot, one-cycle completion.
//   - rsp_data holds its value until the next completion.
//
//   Modports:
//   - master: the arbiter. It consumes requests and memory data, and drives
//     responses, memory requests, status and the debug state.
//   - slave: the surrounding logic. The output engines and the memory drive
//     the request and memory-response side.
//
//   The state signal exposes the arbiter FSM encoding for debug:
//   0 = IDLE, 1 = BUSY, 2 = RESPOND.
interface led_read_arbiter_if #(
  parameter int CHANNELS          = 4,
  parameter int ADDRESS_BUS_WIDTH = 16
);
  logic [CHANNELS-1:0]                   req_request;
  logic [CHANNELS*ADDRESS_BUS_WIDTH-1:0] req_address;
  logic [15:0]                           rsp_data;
  logic [CHANNELS-1:0]                   rsp_strobe;
  logic                                  mem_request;
  logic [ADDRESS_BUS_WIDTH-1:0]          mem_address;
  logic [15:0]                           mem_read_data;
  logic                                  mem_done;
  logic                                  busy;
  logic                                  error_strobe;
  logic [2:0]                            error_channel;
  logic [1:0]                            state;

  modport master (
    input  req_request, req_address, mem_read_data, mem_done,
    output rsp_data, rsp_strobe, mem_request, mem_address, busy,
           error_strobe, error_channel, state
  );

  modport slave (
    output req_request, req_address, mem_read_data, mem_done,
    input  rsp_data, rsp_strobe, mem_request, mem_address, busy,
           error_strobe, error_channel, state
  );
endinterface

// File: rtl/led_read_arbiter.sv
// led_read_arbiter
//   Shares one 16-bit memory read port between CHANNELS LED output drivers.
//   Only one read is outstanding at a time. Grants go round-robin, starting
//   the search one channel past the last grant. A read that the memory does
//   not complete within TIMEOUT BUSY cycles is aborted and reported on
//   error_strobe / error_channel. TIMEOUT = 0 disables the abort.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  led_read_arbiter_if.master, carrying:
//          - requests (req_request, req_address)
//          - responses (rsp_data, rsp_strobe)
//          - the memory port (mem_request, mem_address, mem_read_data, mem_done)
//          - status (busy, error_strobe, error_channel)
//          - the debug FSM state
module led_read_arbiter #(
  parameter int CHANNELS          = 4,
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT           = 255
) (
  input logic               clk,
  input logic               rst,
  led_read_arbiter_if.master bus
);
  localparam int GW = $clog2(CHANNELS);
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CHANNELS-1:0] STROBE_LSB = {{(CHANNELS-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  logic [1:0]                   state;
  logic [GW-1:0]                last_grant;
  logic [CW-1:0]                count;
  logic                         mem_request;
  logic [ADDRESS_BUS_WIDTH-1:0] mem_address;
  logic [15:0]                  rsp_data;
  logic [CHANNELS-1:0]          rsp_strobe;
  logic                         error_strobe;
  logic [2:0]                   error_channel;

  logic          grant_valid;
  logic [GW-1:0] grant_idx;

  // Round-robin pick: scan upward from last_grant+1 with wrap.
  // The nearest requesting channel wins. last_grant itself is scanned last,
  // so a lone requester can still be re-granted.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!grant_valid && bus.req_request[(int'(last_grant) + k) % CHANNELS]) begin
        grant_valid = 1'b1;
        grant_idx   = GW'((int'(last_grant) + k) % CHANNELS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      last_grant    <= GW'(CHANNELS - 1);
      count         <= '0;
      mem_request   <= 1'b0;
      mem_address   <= '0;
      rsp_data      <= '0;
      rsp_strobe    <= '0;
      error_strobe  <= 1'b0;
      error_channel <= '0;
    end else begin
      // Both strobes are single-cycle pulses unless re-armed below.
      rsp_strobe   <= '0;
      error_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            last_grant  <= grant_idx;
            mem_address <= bus.req_address[grant_idx*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
            mem_request <= 1'b1;
            count       <= '0;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          // mem_done is checked first, so a completion in the expiry cycle
          // still counts as a normal read.
          if (bus.mem_done) begin
            mem_request <= 1'b0;
            rsp_data    <= bus.mem_read_data;
            rsp_strobe  <= STROBE_LSB << last_grant;
            state       <= S_RESPOND;
          end else if ((TIMEOUT != 0) && (count == T_LAST)) begin
            mem_request   <= 1'b0;
            error_strobe  <= 1'b1;
            error_channel <= 3'(last_grant);
            state         <= S_IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_RESPOND: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.state         = state;
  assign bus.busy          = (state != S_IDLE);
  assign bus.mem_request   = mem_request;
  assign bus.mem_address   = mem_address;
  assign bus.rsp_data      = rsp_data;
  assign bus.rsp_strobe    = rsp_strobe;
  assign bus.error_strobe  = error_strobe;
  assign bus.error_channel = error_channel;
endmodule

// File: tb/tb_led_read_arbiter.sv
// tb_led_read_arbiter
//   Directed and random checks of led_read_arbiter with CHANNELS = 4,
//   ADDRESS_BUS_WIDTH = 16, TIMEOUT = 8.
//   Inputs change 1 time unit after a rising edge. Outputs are read at the
//   same point, so every value seen is the one registered by that edge.
module tb_led_read_arbiter;
  localparam int CH = 4;
  localparam int AW = 16;
  localparam int TO = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_read_arbiter_if #(.CHANNELS(CH), .ADDRESS_BUS_WIDTH(AW)) bus ();

  led_read_arbiter #(
    .CHANNELS(CH),
    .ADDRESS_BUS_WIDTH(AW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Scoreboard / reference state
  int          total  = 0;
  int          bad    = 0;
  int          last_g = CH - 1;
  logic [15:0] last_data = '0;
  logic [AW-1:0] addr[CH];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_addr;
    for (int i = 0; i < CH; i++) bus.req_address[i*AW +: AW] = addr[i];
  endtask

  // Reference round-robin: first requesting channel after 'last', with wrap.
  function automatic int rr_pick(input int last, input logic [CH-1:0] mask);
    for (int k = 1; k <= CH; k++)
      if (mask[(last + k) % CH]) return (last + k) % CH;
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_request"},   bus.mem_request,   0);
    check({tag, "_mem_address"},   bus.mem_address,   0);
    check({tag, "_rsp_strobe"},    bus.rsp_strobe,    0);
    check({tag, "_rsp_data"},      bus.rsp_data,      0);
    check({tag, "_busy"},          bus.busy,          0);
    check({tag, "_error_strobe"},  bus.error_strobe,  0);
    check({tag, "_error_channel"}, bus.error_channel, 0);
  endtask

  // One read from IDLE with request mask 'mask'.
  // - The memory answers after 'lat' extra BUSY cycles, or never if lat >= TO.
  // - The request is dropped and all addresses are scrambled right after the
  //   grant; the read must go on with the address sampled at the grant.
  task automatic run_txn(input logic [CH-1:0] mask, input int lat, input logic [15:0] data);
    int            ch;
    logic [AW-1:0] a;
    drive_addr();
    bus.req_request = mask;
    ch = rr_pick(last_g, mask);
    a  = addr[ch];
    tick();
    check("grant_mem_request", bus.mem_request, 1);
    check("grant_mem_address", bus.mem_address, a);
    check("grant_busy",        bus.busy,        1);
    last_g = ch;
    bus.req_request = '0;
    for (int i = 0; i < CH; i++) addr[i] = AW'($urandom);
    drive_addr();
    if (lat < TO) begin
      repeat (lat) begin
        bus.mem_read_data = 16'($urandom);
        tick();
        check("wait_mem_request", bus.mem_request, 1);
        check("wait_mem_address", bus.mem_address, a);
        check("wait_rsp_strobe",  bus.rsp_strobe,  0);
      end
      bus.mem_done      = 1'b1;
      bus.mem_read_data = data;
      tick();
      bus.mem_done      = 1'b0;
      bus.mem_read_data = 16'($urandom);
      check("done_rsp_strobe",   bus.rsp_strobe,   32'(1) << ch);
      check("done_rsp_data",     bus.rsp_data,     data);
      check("done_mem_request",  bus.mem_request,  0);
      check("done_error_strobe", bus.error_strobe, 0);
      check("done_busy",         bus.busy,         1);
      last_data = data;
      tick();
      check("after_rsp_strobe", bus.rsp_strobe, 0);
      check("after_busy",       bus.busy,       0);
      check("after_rsp_data",   bus.rsp_data,   last_data);
    end else begin
      repeat (TO - 1) begin
        bus.mem_read_data = 16'($urandom);
        tick();
        check("to_wait_mem_request",  bus.mem_request,  1);
        check("to_wait_rsp_strobe",   bus.rsp_strobe,   0);
        check("to_wait_error_strobe", bus.error_strobe, 0);
      end
      tick();
      check("to_mem_request",   bus.mem_request,   0);
      check("to_error_strobe",  bus.error_strobe,  1);
      check("to_error_channel", bus.error_channel, ch);
      check("to_rsp_strobe",    bus.rsp_strobe,    0);
      check("to_busy",          bus.busy,          0);
      check("to_rsp_data",      bus.rsp_data,      last_data);
      tick();
      check("to_after_error_strobe", bus.error_strobe, 0);
      check("to_after_mem_request",  bus.mem_request,  0);
    end
  endtask

  initial begin
    int            ch;
    logic [15:0]   d;
    logic [CH-1:0] m;

    rst               = 1'b1;
    bus.req_request   = '0;
    bus.req_address   = '0;
    bus.mem_read_data = '0;
    bus.mem_done      = 1'b0;
    for (int i = 0; i < CH; i++) addr[i] = '0;

    // Reset values
    tick();
    tick();
    check_reset_outputs("reset");
    check("reset_state", bus.state, 0);
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset_idle");

    // Channel 2 reads 0x0123; data arrives two cycles after mem_request
    addr[2] = 16'h0123;
    run_txn(4'b0100, 2, 16'hBEEF);

    // Channel 1 drops its request and address after the grant
    addr[1] = 16'h0456;
    run_txn(4'b0010, 0, 16'h1234);

    // Timeout on channel 3 while channel 0 also requests.
    // Channel 0 is served next.
    addr[0] = 16'h0A00;
    addr[3] = 16'h0B33;
    run_txn(4'b1001, TO, 16'h0);
    addr[0] = 16'h0C00;
    run_txn(4'b1001, 1, 16'h5A5A);

    // mem_done in the same cycle the timeout would expire
    run_txn(4'b0100, TO - 1, 16'hC0DE);

    // Reset in BUSY, then a stray mem_done after release
    addr[1] = 16'h0777;
    drive_addr();
    bus.req_request = 4'b0010;
    tick();
    check("mid_grant_mem_request", bus.mem_request, 1);
    bus.req_request = '0;
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    last_g = CH - 1;
    last_data = '0;
    tick();
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    check_reset_outputs("stray_done");

    // All channels request continuously with 1-cycle memory.
    // Expected order is 0,1,2,3,0,1,2,3 with a grant every 3 cycles.
    for (int i = 0; i < CH; i++) addr[i] = AW'(16'h1000 + i);
    drive_addr();
    bus.req_request = '1;
    tick();
    for (int n = 0; n < 2 * CH; n++) begin
      ch = rr_pick(last_g, '1);
      check("rr_order", ch, n % CH);
      check("rr_mem_request", bus.mem_request, 1);
      check("rr_mem_address", bus.mem_address, addr[ch]);
      last_g = ch;
      d = 16'($urandom);
      bus.mem_done = 1'b1;
      bus.mem_read_data = d;
      tick();
      bus.mem_done = 1'b0;
      check("rr_rsp_strobe", bus.rsp_strobe, 32'(1) << ch);
      check("rr_rsp_data",   bus.rsp_data,   d);
      last_data = d;
      if (n == 2 * CH - 1) bus.req_request = '0;
      tick();
      check("rr_gap_mem_request", bus.mem_request, 0);
      tick();
    end
    check("rr_final_idle", bus.busy, 0);

    // Random masks, latencies (some past the timeout), addresses and data
    for (int t = 0; t < 40; t++) begin
      m = CH'($urandom_range(1, (1 << CH) - 1));
      for (int i = 0; i < CH; i++) addr[i] = AW'($urandom);
      run_txn(m, $urandom_range(0, TO + 2), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        bus.mem_done = 1'b1;
        bus.mem_read_data = 16'($urandom);
        tick();
        bus.mem_done = 1'b0;
        check("idle_done_rsp_strobe",  bus.rsp_strobe,  0);
        check("idle_done_mem_request", bus.mem_request, 0);
        check("idle_done_rsp_data",    bus.rsp_data,    last_data);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_read_arbiter.md
# led_read_arbiter

Shares a single 16-bit memory read port between `CHANNELS` LED output drivers. Each driver presents an address and a level read request, and receives a one-cycle completion strobe with data. The block sits between the strip output engines and the frame-buffer memory. It grants one outstanding read at a time, in round-robin order, and aborts reads that the memory never completes.

## Interface
Parameters:
- `CHANNELS`, 4: number of requesters (2..8).
- `ADDRESS_BUS_WIDTH`, 16: address width per requester and toward memory.
- `TIMEOUT`, 255: maximum BUSY cycles before a read is aborted; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `req_request`  in  `CHANNELS`  level read request, one bit per channel.
- `req_address`  in  `CHANNELS*ADDRESS_BUS_WIDTH`  channel i address at `[i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH]`.
- `rsp_data`  out  16  read data; valid while any `rsp_strobe` bit is high.
- `rsp_strobe`  out  `CHANNELS`  one-hot, one-cycle completion strobe.
- `mem_request`  out  1  memory read request; held until the read completes or is aborted.
- `mem_address`  out  `ADDRESS_BUS_WIDTH`  memory read address; stable while `mem_request` is high.
- `mem_read_data`  in  16  memory data; sampled in the cycle `mem_done` is high.
- `mem_done`  in  1  memory completion strobe.
- `busy`  out  1  high in BUSY and RESPOND.
- `error_strobe`  out  1  one-cycle pulse on a timeout abort.
- `error_channel`  out  3  channel of the most recent abort.

## Operation
- FSM states: IDLE, BUSY, RESPOND.
- **IDLE:**
  - If any `req_request` bit is set, grant the first set bit, searching from `(last_grant+1) mod CHANNELS` upward with wrap.
  - On a grant: latch the grant index into `last_grant`; register `mem_address` from that channel's address; set `mem_request` to 1; clear the timeout counter; go to BUSY.
- **BUSY:**
  - If `mem_done` is high: clear `mem_request`; register `rsp_data` from `mem_read_data`; set `rsp_strobe[last_grant]` to 1; go to RESPOND.
  - Otherwise, if `TIMEOUT != 0` and the counter equals `TIMEOUT-1`: clear `mem_request`; pulse `error_strobe`; set `error_channel` to `last_grant`; go to IDLE with no `rsp_strobe`.
  - Otherwise increment the counter.
- **RESPOND:** clear `rsp_strobe`; go to IDLE. `rsp_data` holds its value until the next completion.
- The address is sampled only at grant time. A requester dropping `req_request`, or changing its address, after the grant does not cancel the read; the strobe is still delivered.
- `mem_done` is ignored in IDLE and RESPOND.
- If `mem_done` and timeout expiry occur in the same cycle, `mem_done` wins and the read completes normally.
- The timeout counter width is `$clog2(TIMEOUT+1)`, minimum 1. The counter never wraps: it stops at `TIMEOUT-1` because of the abort.
- Round-robin is fair: a continuously requesting channel waits at most `CHANNELS-1` grants.
- An unused `error_channel` high bit reads 0 when `CHANNELS <= 4`.

## Timing
- Reset values: state IDLE, `mem_request`=0, `mem_address`=0, `rsp_strobe`=0, `rsp_data`=0, `busy`=0, `error_strobe`=0, `error_channel`=0, `last_grant`=`CHANNELS-1` (so channel 0 is granted first).
- Request seen in IDLE at cycle N: `mem_request` and `mem_address` are valid at cycle N+1.
- `mem_done` high at cycle M: `rsp_strobe`/`rsp_data` are valid at M+1, and `mem_request` is low at M+1.
- The next grant is decided at M+2, so the next `mem_request` rises at M+3.
- Minimum transaction period is 3 cycles, when `mem_done` arrives in the first BUSY cycle.
- Timeout: `mem_request` is high for exactly `TIMEOUT` cycles; `error_strobe` is high in the following cycle.
- Reset mid-transaction: all outputs return to reset values on the next edge. No strobe is issued for the aborted read. A `mem_done` arriving after reset is ignored.

## Test plan
- Single channel 2 requests address 0x0123; memory returns 0xBEEF two cycles after `mem_request`:
  - `mem_address`=0x0123 one cycle after the request.
  - `rsp_strobe`=4'b0100 for exactly one cycle, with `rsp_data`=0xBEEF.
  - `busy` falls after RESPOND.
- All four channels request continuously; memory completes in 1 cycle: grant order is 0,1,2,3,0,1… with a new `mem_request` every 3 cycles and no channel skipped.
- Channel 1 drops its request and changes its address the cycle after its grant: memory still sees the original address, and `rsp_strobe[1]` still pulses.
- `TIMEOUT`=8, memory never responds to channel 3:
  - `mem_request` is high for 8 cycles.
  - `error_strobe` pulses once with `error_channel`=3, and no `rsp_strobe`.
  - The next pending channel (0) is granted afterwards.
- `mem_done` coincides with the timeout cycle: a normal completion strobe occurs and `error_strobe` stays 0.
- `rst` asserted in BUSY, with `mem_done` pulsed the cycle after reset releases: all outputs are 0, no strobe is issued, and the first grant after reset goes to channel 0.
